// File: rtl/vpu_pkg.sv
// Shared VPU widths and the destination-port entry type used by the ALU
// writeback path.
package vpu_pkg;

   localparam int OPERAND_WIDTH  = 32;
   localparam int DST_ADDR_WIDTH = 5;
   localparam int DST_FIFO_DEPTH = 4;

   typedef struct packed {
      logic [DST_ADDR_WIDTH-1:0] addr;
      logic [OPERAND_WIDTH-1:0]  data;
   } dst_entry_t;

endpackage

// File: rtl/vpu_dst_fifo.sv
// First-word fall-through FIFO of destination entries with flush and an
// explicit occupancy count so full and empty never alias.
module vpu_dst_fifo
   import vpu_pkg::*;
#(
   parameter int DEPTH = DST_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push,
   input  logic                     pop,
   input  logic                     flush,
   input  dst_entry_t               wr_entry,
   output dst_entry_t               head,
   output logic [$clog2(DEPTH):0]   count
);

   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   dst_entry_t       mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk) begin
      if (!rst_n || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wr_entry;
   end

   assign head = mem[rd_ptr];

endmodule

// File: rtl/vpu_dst_port.sv
// ALU destination port: buffers qualified ALU results and drains them to
// register-file writeback over valid/ready, flagging results dropped when full.
module vpu_dst_port
   import vpu_pkg::*;
#(
   parameter int DATA_WIDTH = OPERAND_WIDTH,
   parameter int ADDR_WIDTH = DST_ADDR_WIDTH,
   parameter int DEPTH      = DST_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     alu_valid_i,
   input  logic [DATA_WIDTH-1:0]    alu_result_i,
   input  logic [ADDR_WIDTH-1:0]    dst_addr_i,
   output logic                     alu_ready_o,
   output logic                     wb_valid_o,
   output logic [DATA_WIDTH-1:0]    wb_data_o,
   output logic [ADDR_WIDTH-1:0]    wb_addr_o,
   input  logic                     wb_ready_i,
   input  logic                     flush_i,
   output logic [$clog2(DEPTH):0]   count_o,
   output logic                     overflow_err_o
);

   localparam int CW = $clog2(DEPTH) + 1;
   localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

   logic          full;
   logic          push;
   logic          pop;
   logic [CW-1:0] count;
   dst_entry_t    wr_entry;
   dst_entry_t    head;

   // Ready is state-only: a pop in the same cycle never frees a slot for a push.
   assign full        = (count == FULL_COUNT);
   assign alu_ready_o = ~full;
   assign wb_valid_o  = (count != '0);
   assign push        = alu_valid_i & alu_ready_o & ~flush_i;
   assign pop         = wb_valid_o & wb_ready_i & ~flush_i;
   assign wr_entry    = '{addr: dst_addr_i, data: alu_result_i};

   vpu_dst_fifo #(
      .DEPTH    (DEPTH)
   ) u_fifo (
      .clk      (clk),
      .rst_n    (rst_n),
      .push     (push),
      .pop      (pop),
      .flush    (flush_i),
      .wr_entry (wr_entry),
      .head     (head),
      .count    (count)
   );

   assign wb_data_o = wb_valid_o ? head.data : '0;
   assign wb_addr_o = wb_valid_o ? head.addr : '0;
   assign count_o   = count;

   // Sticky drop flag; only flush or reset clears it.
   always_ff @(posedge clk) begin
      if (!rst_n || flush_i) begin
         overflow_err_o <= 1'b0;
      end else if (alu_valid_i && full) begin
         overflow_err_o <= 1'b1;
      end
   end

endmodule

// File: tb/tb_vpu_dst_port.sv
// Self-checking bench for vpu_dst_port: a queue scoreboard checks every
// writeback head, plus vector tables and directed corner-case sequences.
module tb_vpu_dst_port;
   import vpu_pkg::*;

   localparam int DEPTH = DST_FIFO_DEPTH;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        alu_valid_i = 1'b0;
   logic [31:0] alu_result_i = '0;
   logic [4:0]  dst_addr_i = '0;
   logic        alu_ready_o;
   logic        wb_valid_o;
   logic [31:0] wb_data_o;
   logic [4:0]  wb_addr_o;
   logic        wb_ready_i = 1'b0;
   logic        flush_i = 1'b0;
   logic [2:0]  count_o;
   logic        overflow_err_o;

   int total = 0;
   int bad = 0;
   bit checking = 1'b0;

   dst_entry_t exp_q[$];
   int         model_count = 0;
   bit         model_ovf = 1'b0;

   typedef struct {
      logic        valid;
      logic [31:0] data;
      logic [4:0]  addr;
      logic        ready;
      logic        flush;
      int          exp_count;
      logic        exp_ready;
      logic        exp_ovf;
   } vec_t;

   vec_t vecs[9];

   vpu_dst_port dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .alu_valid_i    (alu_valid_i),
      .alu_result_i   (alu_result_i),
      .dst_addr_i     (dst_addr_i),
      .alu_ready_o    (alu_ready_o),
      .wb_valid_o     (wb_valid_o),
      .wb_data_o      (wb_data_o),
      .wb_addr_o      (wb_addr_o),
      .wb_ready_i     (wb_ready_i),
      .flush_i        (flush_i),
      .count_o        (count_o),
      .overflow_err_o (overflow_err_o)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h want 0x%0h at %0t", name, actual, expected, $time);
      end
   endtask

   task automatic applyStimulus(input logic valid, input logic [31:0] data,
                                input logic [4:0] addr, input logic ready,
                                input logic flush);
      alu_valid_i  = valid;
      alu_result_i = data;
      dst_addr_i   = addr;
      wb_ready_i   = ready;
      flush_i      = flush;
      @(posedge clk);
      #1;
   endtask

   // Scoreboard: check state before the coming edge, then predict its effect.
   always @(negedge clk) begin
      if (checking) begin
         checkOutput("sb_count", 32'(count_o), 32'(model_count));
         checkOutput("sb_valid", 32'(wb_valid_o), 32'(model_count != 0));
         checkOutput("sb_ready", 32'(alu_ready_o), 32'(model_count != DEPTH));
         checkOutput("sb_ovf", 32'(overflow_err_o), 32'(model_ovf));
         if (model_count == 0) begin
            checkOutput("sb_empty_data", wb_data_o, 32'h0);
            checkOutput("sb_empty_addr", 32'(wb_addr_o), 32'h0);
         end else begin
            checkOutput("sb_head_data", wb_data_o, exp_q[0].data);
            checkOutput("sb_head_addr", 32'(wb_addr_o), 32'(exp_q[0].addr));
         end
      end
      if (!rst_n || flush_i) begin
         exp_q.delete();
         model_ovf = 1'b0;
      end else begin
         if (alu_valid_i && model_count == DEPTH) model_ovf = 1'b1;
         if (model_count != 0 && wb_ready_i) void'(exp_q.pop_front());
         if (alu_valid_i && model_count != DEPTH)
            exp_q.push_back('{addr: dst_addr_i, data: alu_result_i});
      end
      model_count = exp_q.size();
   end

   initial begin
      // Fill to full under back-pressure, overflow once, then drain.
      vecs[0] = '{1'b1, 32'h10, 5'd1, 1'b0, 1'b0, 1, 1'b1, 1'b0};
      vecs[1] = '{1'b1, 32'h11, 5'd2, 1'b0, 1'b0, 2, 1'b1, 1'b0};
      vecs[2] = '{1'b1, 32'h12, 5'd3, 1'b0, 1'b0, 3, 1'b1, 1'b0};
      vecs[3] = '{1'b1, 32'h13, 5'd4, 1'b0, 1'b0, 4, 1'b0, 1'b0};
      vecs[4] = '{1'b1, 32'h14, 5'd5, 1'b0, 1'b0, 4, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 3, 1'b1, 1'b1};
      vecs[6] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 2, 1'b1, 1'b1};
      vecs[7] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 1, 1'b1, 1'b1};
      vecs[8] = '{1'b0, 32'h0,  5'd0, 1'b1, 1'b0, 0, 1'b1, 1'b1};

      rst_n = 1'b0;
      repeat (2) begin
         @(posedge clk);
         #1;
      end
      rst_n = 1'b1;
      checking = 1'b1;
      checkOutput("reset_valid", 32'(wb_valid_o), 32'h0);
      checkOutput("reset_data", wb_data_o, 32'h0);
      checkOutput("reset_addr", 32'(wb_addr_o), 32'h0);
      checkOutput("reset_count", 32'(count_o), 32'h0);
      checkOutput("reset_ovf", 32'(overflow_err_o), 32'h0);
      checkOutput("reset_ready", 32'(alu_ready_o), 32'h1);

      applyStimulus(1'b1, 32'h7, 5'd3, 1'b1, 1'b0);
      checkOutput("single_valid", 32'(wb_valid_o), 32'h1);
      checkOutput("single_data", wb_data_o, 32'h7);
      checkOutput("single_addr", 32'(wb_addr_o), 32'h3);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("single_drained_valid", 32'(wb_valid_o), 32'h0);
      checkOutput("single_drained_count", 32'(count_o), 32'h0);

      for (int i = 0; i < 9; i++) begin
         applyStimulus(vecs[i].valid, vecs[i].data, vecs[i].addr,
                       vecs[i].ready, vecs[i].flush);
         checkOutput($sformatf("vec%0d_count", i), 32'(count_o), 32'(vecs[i].exp_count));
         checkOutput($sformatf("vec%0d_ready", i), 32'(alu_ready_o), 32'(vecs[i].exp_ready));
         checkOutput($sformatf("vec%0d_ovf", i), 32'(overflow_err_o), 32'(vecs[i].exp_ovf));
      end

      applyStimulus(1'b0, 32'h0, 5'd0, 1'b0, 1'b1);
      checkOutput("flush_clears_ovf", 32'(overflow_err_o), 32'h0);

      for (int i = 0; i < 10; i++) begin
         applyStimulus(1'b1, 32'(i), 5'(i + 8), 1'b1, 1'b0);
         checkOutput($sformatf("stream%0d_count", i), 32'(count_o), 32'h1);
         checkOutput($sformatf("stream%0d_data", i), wb_data_o, 32'(i));
      end
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("stream_end_count", 32'(count_o), 32'h0);
      checkOutput("stream_ovf", 32'(overflow_err_o), 32'h0);

      for (int i = 0; i < 4; i++)
         applyStimulus(1'b1, 32'h20 + 32'(i), 5'(i + 16), 1'b0, 1'b0);
      checkOutput("fullpop_pre_count", 32'(count_o), 32'h4);
      applyStimulus(1'b1, 32'h24, 5'd20, 1'b1, 1'b0);
      checkOutput("fullpop_count", 32'(count_o), 32'h3);
      checkOutput("fullpop_ovf", 32'(overflow_err_o), 32'h1);
      checkOutput("fullpop_head", wb_data_o, 32'h21);
      repeat (3) applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("fullpop_drained", 32'(count_o), 32'h0);

      applyStimulus(1'b1, 32'h30, 5'd6, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h31, 5'd7, 1'b0, 1'b0);
      checkOutput("flushpri_pre_count", 32'(count_o), 32'h2);
      applyStimulus(1'b1, 32'h32, 5'd8, 1'b1, 1'b1);
      checkOutput("flushpri_count", 32'(count_o), 32'h0);
      checkOutput("flushpri_valid", 32'(wb_valid_o), 32'h0);
      checkOutput("flushpri_ovf", 32'(overflow_err_o), 32'h0);
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("flushpri_after_valid", 32'(wb_valid_o), 32'h0);

      applyStimulus(1'b1, 32'h40, 5'd9, 1'b0, 1'b0);
      applyStimulus(1'b1, 32'h41, 5'd10, 1'b0, 1'b0);
      rst_n = 1'b0;
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("midreset_count", 32'(count_o), 32'h0);
      checkOutput("midreset_valid", 32'(wb_valid_o), 32'h0);
      rst_n = 1'b1;
      applyStimulus(1'b0, 32'h0, 5'd0, 1'b1, 1'b0);
      checkOutput("midreset_after_ready", 32'(alu_ready_o), 32'h1);

      @(negedge clk);
      #1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
